// File: rtl/memory_if.sv
// memory_if -- data-memory bus between the memory stage and the memory.
//
// Handshake: the master raises mem_req together with mem_we/mem_addr/
// mem_wstrb/mem_wdata and keeps all of them stable until it samples
// mem_ack high on a rising clock edge.  That edge completes the transfer.
// For reads, mem_rdata is taken on that same edge.  The slave may assert
// mem_ack in the first cycle of mem_req.  mem_ack seen while mem_req is
// low has no meaning and is ignored.
//
// Signals:
//   mem_req   master->slave  transfer request
//   mem_we    master->slave  1 = write, 0 = read
//   mem_addr  master->slave  word-aligned byte address
//   mem_wstrb master->slave  byte-lane write strobes (0000 for reads)
//   mem_wdata master->slave  write data, already replicated onto lanes
//   mem_rdata slave->master  read data (whole word)
//   mem_ack   slave->master  transfer complete
interface memory_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/memory.sv
// memory -- pipeline memory stage.
//
// Takes one operation per enable pulse from the execute stage, performs at
// most one data-memory transfer, and hands a registered result to the write
// stage with a one-cycle done pulse.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   enable                start pulse, honoured only while idle
//   mode                  00/11 none, 01 load, 10 store
//   funct3                access size: 000 b, 001 h, 010 w, 100 bu, 101 hu
//   wselector_in, pc_in,
//   rd_in                 passed through to the write stage on capture
//   result                ALU result; byte address for loads/stores
//   sdata                 store data
//   done                  one-cycle completion pulse
//   wselector, pc, rd,
//   data, fault           registered results for the write stage
//   bus                   data-memory bus (master side)
//   state_dbg             current FSM state (0 IDLE, 1 ACCESS, 2 FINISH)
module memory (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [2:0]  funct3,
    input  logic [2:0]  wselector_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] result,
    input  logic [31:0] sdata,
    input  logic [4:0]  rd_in,
    output logic        done,
    output logic [2:0]  wselector,
    output logic [31:0] pc,
    output logic [31:0] data,
    output logic [4:0]  rd,
    output logic        fault,
    memory_if.master    bus,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Captured access shape, needed to pick the load lane on ack.
    logic [2:0] f3_q;
    logic [1:0] off_q;

    logic        capture;
    logic        is_mem;
    logic        is_store;
    logic        cap_fault;
    logic        legal_mem;
    logic [3:0]  st_strb;
    logic [31:0] st_data;
    logic [31:0] rd_shift;
    logic [31:0] load_data;

    assign capture   = (state == IDLE) && enable;
    assign is_mem    = (mode == 2'b01) || (mode == 2'b10);
    assign is_store  = (mode == 2'b10);
    assign legal_mem = is_mem && !cap_fault;

    // Illegal size codes and misaligned halves/words.  Only meaningful
    // when the operation actually touches memory.
    always_comb begin
        cap_fault = 1'b0;
        case (funct3)
            3'b001, 3'b101:         cap_fault = result[0];
            3'b010:                 cap_fault = |result[1:0];
            3'b011, 3'b110, 3'b111: cap_fault = 1'b1;
            default:                cap_fault = 1'b0;
        endcase
    end

    // Store lane placement.  funct3[1:0] gives the size, so the unsigned
    // codes behave as their signed counterparts for stores.
    always_comb begin
        st_strb = 4'b1111;
        st_data = sdata;
        case (funct3[1:0])
            2'b00: begin
                st_strb = 4'b0001 << result[1:0];
                st_data = {4{sdata[7:0]}};
            end
            2'b01: begin
                st_strb = result[1] ? 4'b1100 : 4'b0011;
                st_data = {2{sdata[15:0]}};
            end
            default: begin
                st_strb = 4'b1111;
                st_data = sdata;
            end
        endcase
    end

    // Load lane extraction from the returned word.
    assign rd_shift = bus.mem_rdata >> {off_q, 3'b000};

    always_comb begin
        load_data = bus.mem_rdata;
        case (f3_q)
            3'b000:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b100:  load_data = {24'd0, rd_shift[7:0]};
            3'b001:  load_data = off_q[1] ? {{16{bus.mem_rdata[31]}}, bus.mem_rdata[31:16]}
                                          : {{16{bus.mem_rdata[15]}}, bus.mem_rdata[15:0]};
            3'b101:  load_data = off_q[1] ? {16'd0, bus.mem_rdata[31:16]}
                                          : {16'd0, bus.mem_rdata[15:0]};
            default: load_data = bus.mem_rdata;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = legal_mem ? ACCESS : FINISH;
            ACCESS:  if (bus.mem_ack) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs.  Decoding from the state register lets reset drop
    // mem_req immediately, without waiting for an edge.
    always_comb begin
        done        = (state == FINISH);
        bus.mem_req = (state == ACCESS);
        state_dbg   = state;
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wselector     <= '0;
            pc            <= '0;
            rd            <= '0;
            data          <= '0;
            fault         <= 1'b0;
            f3_q          <= '0;
            off_q         <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wstrb <= '0;
            bus.mem_wdata <= '0;
        end else if (capture) begin
            wselector     <= wselector_in;
            pc            <= pc_in;
            rd            <= rd_in;
            f3_q          <= funct3;
            off_q         <= result[1:0];
            fault         <= is_mem && cap_fault;
            bus.mem_addr  <= {result[31:2], 2'b00};
            bus.mem_we    <= legal_mem && is_store;
            bus.mem_wstrb <= (legal_mem && is_store) ? st_strb : 4'b0000;
            bus.mem_wdata <= (legal_mem && is_store) ? st_data : 32'd0;
            // Loads keep the old value here; it is replaced on ack.
            if (!is_mem)        data <= result;
            else if (cap_fault) data <= '0;
            else if (is_store)  data <= sdata;
        end else if (state == ACCESS && bus.mem_ack && !bus.mem_we) begin
            data <= load_data;
        end
    end

endmodule

// File: tb/tb_memory.sv
module tb_memory;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  mode = '0;
    logic [2:0]  funct3 = '0;
    logic [2:0]  wselector_in = '0;
    logic [31:0] pc_in = '0;
    logic [31:0] result = '0;
    logic [31:0] sdata = '0;
    logic [4:0]  rd_in = '0;
    logic        done;
    logic        fault;
    logic [2:0]  wselector;
    logic [31:0] pc;
    logic [31:0] data;
    logic [4:0]  rd;
    logic [1:0]  state_dbg;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];

    memory_if bus_if();

    memory dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .funct3(funct3),
        .wselector_in(wselector_in), .pc_in(pc_in), .result(result),
        .sdata(sdata), .rd_in(rd_in), .done(done), .wselector(wselector),
        .pc(pc), .data(data), .rd(rd), .fault(fault),
        .bus(bus_if.master), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        int          latency;
        int          dones;
        int          req_cycles;
        bit          saw_req;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] addr;
        logic [31:0] data;
        logic        fault;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [2:0]  ws;
    } obs_t;

    typedef struct {
        bit          access;
        logic        fault;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] addr;
        logic [31:0] data;
        int          latency;
    } exp_t;

    // Reference model: what one operation must produce, from the rules.
    function automatic exp_t model(input logic [1:0] m, input logic [2:0] f3,
                                   input logic [31:0] res, input logic [31:0] sd,
                                   input logic [31:0] rdata, input int dly);
        exp_t e;
        int off, size;
        logic [63:0] lane;
        e = '{default: 0};
        off = int'(res % 4);
        if (!(m == 2'd1 || m == 2'd2)) begin
            e.data = res; e.latency = 1; return e;
        end
        if (f3 == 3 || f3 == 6 || f3 == 7 || ((f3 == 1 || f3 == 5) && (res % 2) != 0)
            || (f3 == 2 && off != 0)) begin
            e.fault = 1'b1; e.data = 32'd0; e.latency = 1; return e;
        end
        e.access = 1;
        e.addr = res - 32'(off);
        e.latency = dly + 2;
        size = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
        if (m == 2'd2) begin
            e.we = 1'b1;
            e.data = sd;
            e.wstrb = 4'(((1 << size) - 1) << off);
            if (size == 1)      e.wdata = (sd & 32'hFF) * 32'h01010101;
            else if (size == 2) e.wdata = (sd & 32'hFFFF) * 32'h00010001;
            else                e.wdata = sd;
        end else begin
            lane = 64'(rdata) >> (8 * off);
            if (size < 4) begin
                lane = lane % (64'd1 << (8 * size));
                if (f3 < 4 && lane >= (64'd1 << (8 * size - 1)))
                    lane = lane - (64'd1 << (8 * size));
            end
            e.data = lane[31:0];
        end
        return e;
    endfunction

    // driver: issue one operation, act as the memory, observe the result
    task automatic do_op(input logic [1:0] m, input logic [2:0] f3,
                         input logic [31:0] res, input logic [31:0] sd,
                         input logic [31:0] pcv, input logic [4:0] rdv,
                         input logic [2:0] ws, input logic [31:0] rdata,
                         input int ack_delay, input bit noisy, output obs_t o);
        o = '{default: 0};
        @(negedge clk);
        mode = m; funct3 = f3; result = res; sdata = sd; pc_in = pcv;
        rd_in = rdv; wselector_in = ws; enable = 1'b1; bus_if.mem_ack = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done) begin
                o.dones++;
                if (o.latency == 0) begin
                    o.latency = c; o.data = data; o.fault = fault;
                    o.pc = pc; o.rd = rd; o.ws = wselector;
                end
            end
            enable = noisy && (o.latency == 0 || o.latency == c);
            if (noisy) begin
                mode = 2'($urandom); funct3 = 3'($urandom); result = $urandom;
                sdata = $urandom; pc_in = $urandom; rd_in = 5'($urandom);
                wselector_in = 3'($urandom);
            end
            if (bus_if.mem_req) begin
                if (!o.saw_req) begin
                    o.we = bus_if.mem_we; o.wstrb = bus_if.mem_wstrb;
                    o.wdata = bus_if.mem_wdata; o.addr = bus_if.mem_addr;
                end
                o.saw_req = 1;
                o.req_cycles++;
                if (o.req_cycles > ack_delay) begin
                    bus_if.mem_ack = 1'b1; bus_if.mem_rdata = rdata;
                end else begin
                    bus_if.mem_ack = 1'b0; bus_if.mem_rdata = $urandom;
                end
            end else begin
                bus_if.mem_ack = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            if (o.latency != 0 && c >= o.latency + 2) break;
        end
        enable = 1'b0;
        bus_if.mem_ack = 1'b0;
    endtask

    task automatic test_reset;
        #2 rst = 1'b1;
        #1;
        vectors++; if (done !== 1'b0 || bus_if.mem_req !== 1'b0) begin miscompares++;
            $display("FAIL reset_ctrl: done=%b mem_req=%b want 0 0", done, bus_if.mem_req); end
        vectors++; if ({fault, data, pc, rd, wselector} !== '0) begin miscompares++;
            $display("FAIL reset_outs: got %h want 0", {fault, data, pc, rd, wselector}); end
        vectors++; if ({bus_if.mem_we, bus_if.mem_wstrb, bus_if.mem_addr, bus_if.mem_wdata} !== '0) begin
            miscompares++; $display("FAIL reset_bus: got %h want 0",
                {bus_if.mem_we, bus_if.mem_wstrb, bus_if.mem_addr, bus_if.mem_wdata}); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_none;
        obs_t o;
        do_op(2'b00, 3'b000, 32'h00001234, 32'hDEAD0000, 32'h00000400, 5'd5, 3'd2, 32'h0, 0, 0, o);
        vectors++; if (o.latency !== 1) begin miscompares++; $display("FAIL none_latency: got %0d want 1", o.latency); end
        vectors++; if (o.data !== 32'h00001234) begin miscompares++; $display("FAIL none_data: got %h want 00001234", o.data); end
        vectors++; if (o.rd !== 5'd5 || o.pc !== 32'h400 || o.ws !== 3'd2) begin miscompares++;
            $display("FAIL none_pass: got rd=%0d pc=%h ws=%0d want 5 400 2", o.rd, o.pc, o.ws); end
        vectors++; if (o.saw_req !== 1'b0 || o.fault !== 1'b0) begin miscompares++;
            $display("FAIL none_req: got req=%b fault=%b want 0 0", o.saw_req, o.fault); end
        do_op(2'b11, 3'b111, 32'h0BADF00D, 32'h0, 32'h0, 5'd1, 3'd0, 32'h0, 0, 0, o);
        vectors++; if (o.data !== 32'h0BADF00D || o.fault !== 1'b0 || o.saw_req !== 1'b0 || o.latency !== 1) begin
            miscompares++; $display("FAIL none11: got data=%h fault=%b req=%b lat=%0d want 0badf00d 0 0 1",
                o.data, o.fault, o.saw_req, o.latency); end
    endtask

    task automatic test_load;
        obs_t o;
        logic [2:0]  f3s[5]  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [31:0] ress[5] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100};
        logic [31:0] exps[5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'h80FF7F01};
        int          lats[5] = '{4, 4, 3, 3, 2};
        for (int i = 0; i < 5; i++) begin
            do_op(2'b01, f3s[i], ress[i], 32'h0, 32'h10, 5'd3, 3'd1, 32'h80FF7F01, lats[i] - 2, 0, o);
            vectors++; if (o.data !== exps[i]) begin miscompares++;
                $display("FAIL load_data[%0d]: got %h want %h", i, o.data, exps[i]); end
            vectors++; if (o.latency !== lats[i] || o.dones !== 1) begin miscompares++;
                $display("FAIL load_timing[%0d]: got lat=%0d dones=%0d want %0d 1", i, o.latency, o.dones, lats[i]); end
            vectors++; if (o.addr !== 32'h100 || o.we !== 1'b0 || o.wstrb !== 4'b0000) begin miscompares++;
                $display("FAIL load_bus[%0d]: got addr=%h we=%b strb=%b want 100 0 0000", i, o.addr, o.we, o.wstrb); end
        end
    endtask

    task automatic test_store;
        obs_t o;
        do_op(2'b10, 3'b001, 32'h202, 32'h0000BEEF, 32'h20, 5'd0, 3'd0, 32'h0, 1, 0, o);
        vectors++; if (o.we !== 1'b1 || o.wstrb !== 4'b1100 || o.wdata !== 32'hBEEFBEEF || o.addr !== 32'h200) begin
            miscompares++; $display("FAIL sh_bus: got we=%b strb=%b wdata=%h addr=%h want 1 1100 beefbeef 200",
                o.we, o.wstrb, o.wdata, o.addr); end
        vectors++; if (o.data !== 32'h0000BEEF || o.fault !== 1'b0 || o.latency !== 3) begin miscompares++;
            $display("FAIL sh_result: got data=%h fault=%b lat=%0d want 0000beef 0 3", o.data, o.fault, o.latency); end
        do_op(2'b10, 3'b000, 32'h203, 32'h12345678, 32'h24, 5'd0, 3'd0, 32'h0, 0, 0, o);
        vectors++; if (o.wstrb !== 4'b1000 || o.wdata !== 32'h78787878 || o.addr !== 32'h200) begin
            miscompares++; $display("FAIL sb_bus: got strb=%b wdata=%h addr=%h want 1000 78787878 200",
                o.wstrb, o.wdata, o.addr); end
        do_op(2'b10, 3'b010, 32'h208, 32'hA5A5C3C3, 32'h28, 5'd0, 3'd0, 32'h0, 3, 0, o);
        vectors++; if (o.wstrb !== 4'b1111 || o.wdata !== 32'hA5A5C3C3 || o.latency !== 5) begin
            miscompares++; $display("FAIL sw_bus: got strb=%b wdata=%h lat=%0d want 1111 a5a5c3c3 5",
                o.wstrb, o.wdata, o.latency); end
    endtask

    task automatic test_fault;
        obs_t o;
        do_op(2'b01, 3'b010, 32'h6, 32'h0, 32'h30, 5'd4, 3'd3, 32'h0, 0, 0, o);
        vectors++; if (o.fault !== 1'b1 || o.data !== 32'h0 || o.saw_req !== 1'b0 || o.latency !== 1) begin
            miscompares++; $display("FAIL lw_misaligned: got fault=%b data=%h req=%b lat=%0d want 1 0 0 1",
                o.fault, o.data, o.saw_req, o.latency); end
        vectors++; if (fault !== 1'b1) begin miscompares++; $display("FAIL fault_hold: got %b want 1", fault); end
        do_op(2'b10, 3'b011, 32'h8, 32'h0, 32'h34, 5'd4, 3'd3, 32'h0, 0, 0, o);
        vectors++; if (o.fault !== 1'b1 || o.saw_req !== 1'b0) begin miscompares++;
            $display("FAIL bad_funct3: got fault=%b req=%b want 1 0", o.fault, o.saw_req); end
        do_op(2'b10, 3'b001, 32'h201, 32'h0, 32'h38, 5'd4, 3'd3, 32'h0, 0, 0, o);
        vectors++; if (o.fault !== 1'b1 || o.saw_req !== 1'b0) begin miscompares++;
            $display("FAIL sh_odd: got fault=%b req=%b want 1 0", o.fault, o.saw_req); end
    endtask

    task automatic test_reset_abort;
        obs_t o;
        bit dseen;
        @(negedge clk);
        mode = 2'b01; funct3 = 3'b010; result = 32'h40; rd_in = 5'd7;
        pc_in = 32'h500; enable = 1'b1; bus_if.mem_ack = 1'b0;
        @(negedge clk);
        enable = 1'b0;
        vectors++; if (bus_if.mem_req !== 1'b1) begin miscompares++;
            $display("FAIL abort_req_up: got %b want 1", bus_if.mem_req); end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++; if (bus_if.mem_req !== 1'b0 || done !== 1'b0) begin miscompares++;
            $display("FAIL abort_req_drop: got req=%b done=%b want 0 0", bus_if.mem_req, done); end
        vectors++; if ({data, pc, rd, fault, bus_if.mem_addr} !== '0) begin miscompares++;
            $display("FAIL abort_outs: got %h want 0", {data, pc, rd, fault, bus_if.mem_addr}); end
        @(negedge clk);
        rst = 1'b0;
        dseen = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || bus_if.mem_req) dseen = 1;
            bus_if.mem_ack = 1'b1;
        end
        bus_if.mem_ack = 1'b0;
        vectors++; if (dseen !== 1'b0) begin miscompares++;
            $display("FAIL abort_no_done: got activity=%b want 0", dseen); end
        do_op(2'b01, 3'b010, 32'h80, 32'h0, 32'h504, 5'd8, 3'd1, 32'h13579BDF, 1, 0, o);
        vectors++; if (o.data !== 32'h13579BDF || o.latency !== 3 || o.rd !== 5'd8) begin miscompares++;
            $display("FAIL abort_recover: got data=%h lat=%0d rd=%0d want 13579bdf 3 8", o.data, o.latency, o.rd); end
    endtask

    task automatic test_reset_release_enable;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; enable = 1'b1; mode = 2'b00; result = 32'hCAFE0001; rd_in = 5'd9;
        @(negedge clk);
        enable = 1'b0;
        vectors++; if (done !== 1'b1 || data !== 32'hCAFE0001 || rd !== 5'd9) begin miscompares++;
            $display("FAIL release_enable: got done=%b data=%h rd=%0d want 1 cafe0001 9", done, data, rd); end
        @(negedge clk);
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL release_done_once: got %b want 0", done); end
    endtask

    task automatic test_enable_ignored;
        obs_t o;
        do_op(2'b01, 3'b000, 32'h301, 32'h0, 32'h600, 5'd11, 3'd5, 32'h0000F200, 3, 1, o);
        vectors++; if (o.dones !== 1 || o.latency !== 5) begin miscompares++;
            $display("FAIL ign_load_timing: got dones=%0d lat=%0d want 1 5", o.dones, o.latency); end
        vectors++; if (o.data !== 32'hFFFFFFF2 || o.pc !== 32'h600 || o.rd !== 5'd11 || o.ws !== 3'd5) begin
            miscompares++; $display("FAIL ign_load_outs: got data=%h pc=%h rd=%0d ws=%0d want fffffff2 600 11 5",
                o.data, o.pc, o.rd, o.ws); end
        do_op(2'b00, 3'b000, 32'h77, 32'h0, 32'h604, 5'd12, 3'd6, 32'h0, 0, 1, o);
        vectors++; if (o.dones !== 1 || o.data !== 32'h77) begin miscompares++;
            $display("FAIL ign_none: got dones=%0d data=%h want 1 00000077", o.dones, o.data); end
    endtask

    task automatic test_random;
        obs_t o;
        exp_t e;
        logic [1:0]  m;
        logic [2:0]  f3, ws;
        logic [31:0] res, sd, rdat, pcv, want;
        logic [4:0]  rdv;
        int dly;
        bit noisy;
        for (int i = 0; i < 80; i++) begin
            m = 2'($urandom); f3 = 3'($urandom); res = $urandom; sd = $urandom;
            rdat = $urandom; pcv = $urandom; rdv = 5'($urandom); ws = 3'($urandom);
            dly = $urandom_range(0, 4); noisy = 1'($urandom_range(0, 1));
            e = model(m, f3, res, sd, rdat, dly);
            exp_q.push_back(e.data);
            do_op(m, f3, res, sd, pcv, rdv, ws, rdat, dly, noisy, o);
            want = exp_q.pop_front();
            vectors++; if (o.data !== want || o.fault !== e.fault) begin miscompares++;
                $display("FAIL rand_data[%0d]: got data=%h fault=%b want %h %b", i, o.data, o.fault, want, e.fault); end
            vectors++; if (o.latency !== e.latency || o.dones !== 1 || o.saw_req !== e.access) begin miscompares++;
                $display("FAIL rand_timing[%0d]: got lat=%0d dones=%0d req=%b want %0d 1 %b",
                    i, o.latency, o.dones, o.saw_req, e.latency, e.access); end
            vectors++; if (o.pc !== pcv || o.rd !== rdv || o.ws !== ws) begin miscompares++;
                $display("FAIL rand_pass[%0d]: got pc=%h rd=%0d ws=%0d want %h %0d %0d", i, o.pc, o.rd, o.ws, pcv, rdv, ws); end
            if (e.access) begin
                vectors++; if (o.addr !== e.addr || o.we !== e.we || o.wstrb !== e.wstrb
                               || (e.we && o.wdata !== e.wdata)) begin miscompares++;
                    $display("FAIL rand_bus[%0d]: got addr=%h we=%b strb=%b wdata=%h want %h %b %b %h",
                        i, o.addr, o.we, o.wstrb, o.wdata, e.addr, e.we, e.wstrb, e.wdata); end
            end
        end
    endtask

    initial begin
        bus_if.mem_ack = 1'b0;
        bus_if.mem_rdata = '0;
        test_reset();
        test_none();
        test_load();
        test_store();
        test_fault();
        test_reset_abort();
        test_reset_release_enable();
        test_enable_ignored();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
